// File: rtl/prog_loader_if.sv
// Signal bundle between the host/core side and prog_loader: byte stream in,
// instruction-memory write port out, and the core run-control handshake.
interface prog_loader_if #(
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned INSTR_WIDTH = 9,
  parameter int unsigned CYC_WIDTH   = 16
);
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   clear;
  logic                   imem_wr_en;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_wr_data;
  logic                   core_reset;
  logic                   req;
  logic                   done;
  logic                   busy;
  logic                   run_done;
  logic [CYC_WIDTH-1:0]   run_cycles;
  logic                   err;
  logic [2:0]             err_code;

  modport master (
    output in_data, in_valid, clear, done,
    input  in_ready, imem_wr_en, imem_addr, imem_wr_data, core_reset, req,
           busy, run_done, run_cycles, err, err_code
  );

  modport slave (
    input  in_data, in_valid, clear, done,
    output in_ready, imem_wr_en, imem_addr, imem_wr_data, core_reset, req,
           busy, run_done, run_cycles, err, err_code
  );
endinterface

// File: rtl/prog_loader.sv
// Host-side program loader and run controller: assembles 9-bit words from a
// byte stream, writes them to instruction memory, then starts and times the core.
module prog_loader #(
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned INSTR_WIDTH = 9,
  parameter int unsigned CYC_WIDTH   = 16,
  parameter int unsigned TIMEOUT     = 50000
) (
  input  logic           clk,
  input  logic           reset,
  prog_loader_if.slave   bus
);

  localparam logic [CYC_WIDTH-1:0] TIMEOUT_C = CYC_WIDTH'(TIMEOUT);

  typedef enum logic [3:0] {
    S_LEN_LO, S_LEN_HI, S_INSTR_LO, S_INSTR_HI, S_FLUSH,
    S_START, S_RUN, S_DONE, S_ERR
  } state_e;

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    len_q;
  logic [PC_WIDTH-1:0]    cnt_q;
  logic [PC_WIDTH-1:0]    cnt_d;
  logic [7:0]             lo_q;
  logic [CYC_WIDTH-1:0]   cyc_q;
  logic [CYC_WIDTH-1:0]   run_cycles_q;
  logic                   wr_en_q;
  logic [PC_WIDTH-1:0]    addr_q;
  logic [INSTR_WIDTH-1:0] wdata_q;
  logic                   req_q;
  logic [2:0]             err_code_q;
  logic [PC_WIDTH-1:0]    len_full_c;
  logic                   xfer_c;

  assign cnt_d      = cnt_q + PC_WIDTH'(1);
  assign len_full_c = PC_WIDTH'({bus.in_data[3:0], len_q[7:0]});
  assign xfer_c     = bus.in_valid & bus.in_ready;

  // Status outputs are pure decodes of the registered state.
  assign bus.in_ready   = ~reset && (state_q inside {S_LEN_LO, S_LEN_HI, S_INSTR_LO, S_INSTR_HI});
  assign bus.core_reset = !(state_q inside {S_START, S_RUN, S_DONE});
  assign bus.busy       = !(state_q inside {S_DONE, S_ERR});
  assign bus.run_done   = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERR);

  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wr_data = wdata_q;
  assign bus.req          = req_q;
  assign bus.run_cycles   = run_cycles_q;
  assign bus.err_code     = err_code_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN_LO;
      len_q        <= '0;
      cnt_q        <= '0;
      lo_q         <= '0;
      cyc_q        <= '0;
      run_cycles_q <= '0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_q        <= 1'b0;
      err_code_q   <= 3'd0;
    end else begin
      wr_en_q <= 1'b0;
      req_q   <= 1'b0;
      case (state_q)
        S_LEN_LO: begin
          if (xfer_c) begin
            len_q   <= PC_WIDTH'(bus.in_data);
            state_q <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer_c) begin
            if (bus.in_data[7:4] != 4'd0) begin
              err_code_q <= 3'd1;
              state_q    <= S_ERR;
            end else if (len_full_c == '0) begin
              err_code_q <= 3'd2;
              state_q    <= S_ERR;
            end else begin
              len_q   <= len_full_c;
              cnt_q   <= '0;
              state_q <= S_INSTR_LO;
            end
          end
        end
        S_INSTR_LO: begin
          if (xfer_c) begin
            lo_q    <= bus.in_data;
            state_q <= S_INSTR_HI;
          end
        end
        S_INSTR_HI: begin
          if (xfer_c) begin
            if (bus.in_data[7:1] != 7'd0) begin
              err_code_q <= 3'd3;
              state_q    <= S_ERR;
            end else begin
              wr_en_q <= 1'b1;
              addr_q  <= cnt_q;
              wdata_q <= INSTR_WIDTH'({bus.in_data[0], lo_q});
              cnt_q   <= cnt_d;
              state_q <= (cnt_d == len_q) ? S_FLUSH : S_INSTR_LO;
            end
          end
        end
        // FLUSH carries the last write strobe; req is registered so it lands in START.
        S_FLUSH: begin
          req_q   <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
          cyc_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (bus.done) begin
            run_cycles_q <= cyc_q;
            state_q      <= S_DONE;
          end else if ((TIMEOUT != 0) && (cyc_q == TIMEOUT_C)) begin
            err_code_q <= 3'd4;
            state_q    <= S_ERR;
          end else if (cyc_q != '1) begin
            cyc_q <= cyc_q + CYC_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (bus.clear) state_q <= S_LEN_LO;
        end
        S_ERR: begin
          if (bus.clear) begin
            err_code_q <= 3'd0;
            state_q    <= S_LEN_LO;
          end
        end
        default: state_q <= S_LEN_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: write scoreboard, error-vector table,
// and hand-written run, timeout, random-valid and mid-load-reset sequences.
module tb_prog_loader;
  localparam int unsigned PC_W = 12;
  localparam int unsigned IW   = 9;
  localparam int unsigned CW   = 16;
  localparam int unsigned TO   = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_loader_if #(.PC_WIDTH(PC_W), .INSTR_WIDTH(IW), .CYC_WIDTH(CW)) bus ();

  prog_loader #(.PC_WIDTH(PC_W), .INSTR_WIDTH(IW), .CYC_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [PC_W-1:0] addr;
    logic [IW-1:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0] stim;   // bytes sent MSB first
    int          n;
    logic [2:0]  code;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   n_cmp, n_bad, cyc_n, req_n, req_cyc, last_wr_cyc, wr_n, w0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample 1ns after the edge and run the write scoreboard.
  task automatic cycle();
    wr_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (bus.imem_wr_en) begin
      wr_n++;
      last_wr_cyc = cyc_n;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 bus.imem_addr, bus.imem_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("wr_data", 32'(bus.imem_wr_data), 32'(e.data));
      end
    end
    if (bus.req) begin
      req_n++;
      req_cyc = cyc_n;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit sent;
    sent = 1'b0;
    bus.in_data = b;
    for (int i = 0; i < 200 && !sent; i++) begin
      bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sent = bus.in_valid && bus.in_ready;
      cycle();
    end
    bus.in_valid = 1'b0;
    if (!sent) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept: byte 0x%0h not taken, expected transfer", b);
    end
  endtask

  task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                           input logic [PC_W-1:0] addr, input bit rnd);
    wr_t e;
    send_byte(lo, rnd);
    e.addr = addr;
    e.data = {hi[0], lo};
    exp_q.push_back(e);
    send_byte(hi, rnd);
  endtask

  task automatic wait_req();
    int r0;
    r0 = req_n;
    for (int i = 0; i < 10 && req_n == r0; i++) cycle();
    chk("req_seen", 32'(req_n - r0), 32'd1);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    chk("clear_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clear_busy", 32'(bus.busy), 32'd1);
    chk("clear_err_code", 32'(bus.err_code), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc_n = 0; req_n = 0; req_cyc = 0; last_wr_cyc = 0; wr_n = 0; w0 = 0;
    vecs[0] = '{32'h0000_0000, 2, 3'd2};
    vecs[1] = '{32'h0110_0000, 2, 3'd1};
    vecs[2] = '{32'h0100_1202, 4, 3'd3};
    vecs[3] = '{32'hFFF0_0000, 2, 3'd1};
    vecs[4] = '{32'h0100_0080, 4, 3'd3};

    reset = 1'b1;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.clear = 1'b0; bus.done = 1'b0;
    cycle();
    cycle();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_run_done", 32'(bus.run_done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_code", 32'(bus.err_code), 32'd0);
    chk("rst_run_cycles", 32'(bus.run_cycles), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.imem_wr_data), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic two-word load and a 5-cycle run.
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(8'h34, 8'h01, 12'd0, 1'b0);
    send_word(8'hFF, 8'h00, 12'd1, 1'b0);
    chk("flush_wr_en", 32'(bus.imem_wr_en), 32'd1);
    chk("flush_core_reset", 32'(bus.core_reset), 32'd1);
    chk("flush_req", 32'(bus.req), 32'd0);
    wait_req();
    chk("start_core_reset", 32'(bus.core_reset), 32'd0);
    chk("req_after_write", 32'(req_cyc > last_wr_cyc), 32'd1);
    chk("req_count", 32'(req_n), 32'd1);
    bus.done = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("req_one_pulse", 32'(req_n), 32'd1);
    chk("run_not_done", 32'(bus.run_done), 32'd0);
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    chk("run_done", 32'(bus.run_done), 32'd1);
    chk("run_cycles", 32'(bus.run_cycles), 32'd5);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_core_reset", 32'(bus.core_reset), 32'd0);
    for (int i = 0; i < 3; i++) cycle();
    chk("run_done_hold", 32'(bus.run_done), 32'd1);
    do_clear();
    chk("clear_run_done", 32'(bus.run_done), 32'd0);
    chk("run_cycles_kept", 32'(bus.run_cycles), 32'd5);

    // Error vectors: none of these may produce a write.
    for (int v = 0; v < 5; v++) begin
      w0 = wr_n;
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].stim[31-8*k -: 8], 1'b0);
      chk("vec_err", 32'(bus.err), 32'd1);
      chk("vec_err_code", 32'(bus.err_code), 32'(vecs[v].code));
      chk("vec_busy", 32'(bus.busy), 32'd0);
      chk("vec_core_reset", 32'(bus.core_reset), 32'd1);
      chk("vec_in_ready", 32'(bus.in_ready), 32'd0);
      cycle();
      chk("vec_err_hold", 32'(bus.err_code), 32'(vecs[v].code));
      chk("vec_no_write", 32'(wr_n), 32'(w0));
      do_clear();
      chk("vec_err_clr", 32'(bus.err), 32'd0);
    end

    // Timeout: 1 START cycle, 20 counted RUN cycles, 1 RUN cycle that sees
    // counter == TIMEOUT, so err is visible 22 samples after req.
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(8'hAA, 8'h00, 12'd0, 1'b0);
    wait_req();
    bus.done = 1'b0;
    for (int i = 0; i < 100 && !bus.err; i++) cycle();
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_latency", 32'(cyc_n - req_cyc), 32'd22);
    chk("to_err_code", 32'(bus.err_code), 32'd4);
    chk("to_core_reset", 32'(bus.core_reset), 32'd1);
    do_clear();

    // Random in_valid during a 3-word load.
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(8'h11, 8'h01, 12'd0, 1'b1);
    send_word(8'h22, 8'h00, 12'd1, 1'b1);
    send_word(8'h33, 8'h01, 12'd2, 1'b1);
    wait_req();
    bus.done = 1'b1;
    for (int i = 0; i < 10 && !bus.run_done; i++) cycle();
    bus.done = 1'b0;
    chk("rnd_run_done", 32'(bus.run_done), 32'd1);
    chk("rnd_run_cycles", 32'(bus.run_cycles), 32'd0);
    chk("rnd_sb_empty", 32'(exp_q.size()), 32'd0);
    do_clear();

    // Reset after the first word of a two-word load.
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(8'h55, 8'h01, 12'd0, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    cycle();
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd1);
    chk("mid_rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("mid_rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.imem_wr_data), 32'd0);
    chk("mid_rst_wr_en", 32'(bus.imem_wr_en), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    bus.done = 1'b1;
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("done_ignored_run_done", 32'(bus.run_done), 32'd0);
    chk("done_ignored_busy", 32'(bus.busy), 32'd1);
    send_word(8'h77, 8'h01, 12'd0, 1'b0);
    chk("done_ignored_flush", 32'(bus.run_done), 32'd0);
    wait_req();
    bus.done = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    chk("fresh_run_done", 32'(bus.run_done), 32'd1);
    chk("fresh_run_cycles", 32'(bus.run_cycles), 32'd3);
    do_clear();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
